uart_reg_responder: RTL and testbench
=====================================

Name: uart_reg_responder

Overview:
- Byte-level command responder that sits behind a UART byte link.
- Consumes received bytes (rx_valid/rx_data pulse stream) and parses host frames: SYNC, CMD, ADDR, optional DATA.
- Issues single-cycle register read/write strobes on a simple local register bus.
- Returns a two-byte response through the UART transmit handshake (tx_rdy/tx_vld/tx_data); it is the device-side end answering a host initiator.

Parameters:
- DATA_BITS, 8, UART byte width; also register data/address width.
- SYNC_BYTE, 8'hA5, request start marker.
- RESP_SYNC, 8'h5A, response start marker.
- TIMEOUT_CLKS, 4800000, max clk cycles between bytes inside a frame before abort (100 ms at 48 MHz).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rx_valid  in  1  one-cycle pulse, rx_data holds a new byte
- rx_data  in  DATA_BITS  received byte
- tx_rdy  in  1  transmitter idle, can accept a byte
- tx_vld  out  1  tx_data valid; transfer occurs on cycle tx_vld && tx_rdy
- tx_data  out  DATA_BITS  byte to transmit
- reg_wr_en  out  1  one-cycle register write strobe
- reg_rd_en  out  1  one-cycle register read strobe
- reg_addr  out  DATA_BITS  register address, held from ADDR byte until next frame
- reg_wdata  out  DATA_BITS  write data, held with reg_addr
- reg_rdata  in  DATA_BITS  read data, valid exactly 1 cycle after reg_rd_en
- busy  out  1  high from SYNC accepted until last response byte transferred
- rx_overrun  out  1  sticky: byte arrived while in EXEC/RD_WAIT/TX states; cleared only by reset

Behaviour:
- Reset values: tx_vld=0, tx_data=0, reg_wr_en=0, reg_rd_en=0, reg_addr=0, reg_wdata=0, busy=0, rx_overrun=0; FSM=IDLE; timeout counter=0. Reset mid-frame or mid-response aborts immediately; a byte already handed to the transmitter is not recalled.
- Commands: 8'h01 WRITE (4-byte frame: SYNC, CMD, ADDR, DATA); 8'h02 READ (3-byte frame: SYNC, CMD, ADDR); any other CMD value is a NAK.
- Responses: WRITE -> RESP_SYNC, 8'h01 (ACK). READ -> RESP_SYNC, reg_rdata captured. Bad CMD -> RESP_SYNC, 8'hEE.
- FSM states:
  - IDLE: wait for rx_valid && rx_data==SYNC_BYTE, then go to CMD and set busy=1; other bytes are silently discarded.
  - CMD: on rx_valid latch cmd. Unknown cmd -> TX_HDR with NAK payload; the frame is not consumed further.
  - ADDR: latch reg_addr. READ -> EXEC; WRITE -> DATA.
  - DATA: latch reg_wdata -> EXEC.
  - EXEC: one cycle. Pulse reg_wr_en (WRITE) or reg_rd_en (READ). WRITE -> TX_HDR; READ -> RD_WAIT.
  - RD_WAIT: one cycle. Capture reg_rdata into the payload register -> TX_HDR.
  - TX_HDR: drive tx_vld=1, tx_data=RESP_SYNC until tx_rdy sampled high; on transfer drop tx_vld for at least one cycle -> TX_PAY.
  - TX_PAY: same handshake with the payload byte; on transfer -> IDLE and busy=0.
- tx_vld is asserted only when entering a TX state or after a gap cycle. It is never held high across two consecutive transfers, so the transmitter has time to drop tx_rdy.
- Latency: last request byte pulse -> reg strobe is 1 cycle; -> tx_vld high is 2 cycles for WRITE, 3 cycles for READ.
- Timeout:
  - Counter resets on every rx_valid and counts in CMD, ADDR and DATA only.
  - Reaching TIMEOUT_CLKS-1 returns the FSM to IDLE with busy=0 and no response.
  - The counter saturates and never wraps.
- A SYNC_BYTE value received in CMD, ADDR or DATA is treated as data, not as a resync.
- rx_valid during EXEC, RD_WAIT or TX states: byte dropped and rx_overrun set. If rx_valid coincides with the final tx transfer, the byte is still dropped.
- Simultaneous reg strobes never occur.

Optional Feature:
- Macro UART_RESP_CHKSUM_EN.
- When defined:
  - Request carries a trailing CHK byte = XOR of CMD, ADDR and DATA (DATA only for WRITE), received in added state CHK before EXEC.
  - On mismatch there is no register access and the response is RESP_SYNC, 8'hEC.
  - Every response gains a third byte = XOR of its payload byte with RESP_SYNC, sent from added state TX_CHK.
  - Unknown-cmd NAK responses also carry the third byte.
- When undefined: no CHK/TX_CHK states, frames and responses exactly as above.

Test Plan:
- Send A5 01 10 3C -> one-cycle reg_wr_en with reg_addr=10, reg_wdata=3C; tx bytes 5A, 01; busy low after second transfer.
- Send A5 02 22 with reg_rdata=C7 one cycle after reg_rd_en -> tx bytes 5A, C7; reg_wr_en never asserted.
- Send 00 FF A5 07 -> leading bytes ignored; response 5A, EE; no reg strobes.
- Send A5 01 then stall TIMEOUT_CLKS cycles, then send 10 -> FSM back in IDLE, no response; the late byte 10 is ignored as non-sync.
- Hold tx_rdy low 500 cycles during a READ response, then send rx byte 55 while waiting -> tx_vld stays high with 5A until tx_rdy rises; rx_overrun=1; response completes unchanged.
- With UART_RESP_CHKSUM_EN: A5 01 10 3C 2D -> write performed, tx 5A 01 5B. A5 01 10 3C 00 -> no write, tx 5A EC B6.

Source files
------------

// File: rtl/uart_reg_responder.sv
// uart_reg_responder: device-side command responder behind a UART byte link.
// Parses SYNC/CMD/ADDR[/DATA] request frames, issues single-cycle register
// read/write strobes and returns a RESP_SYNC-prefixed response byte stream.
// Optional build macro UART_RESP_CHKSUM_EN adds a trailing XOR check byte to
// requests and a third XOR byte to every response.
module uart_reg_responder #(
    parameter int unsigned           DATA_BITS    = 8,
    parameter logic [DATA_BITS-1:0]  SYNC_BYTE    = 8'hA5,
    parameter logic [DATA_BITS-1:0]  RESP_SYNC    = 8'h5A,
    parameter int unsigned           TIMEOUT_CLKS = 4800000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_valid,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 tx_rdy,
    output logic                 tx_vld,
    output logic [DATA_BITS-1:0] tx_data,
    output logic                 reg_wr_en,
    output logic                 reg_rd_en,
    output logic [DATA_BITS-1:0] reg_addr,
    output logic [DATA_BITS-1:0] reg_wdata,
    input  logic [DATA_BITS-1:0] reg_rdata,
    output logic                 busy,
    output logic                 rx_overrun
);

    localparam logic [DATA_BITS-1:0] CmdWrite = DATA_BITS'(8'h01);
    localparam logic [DATA_BITS-1:0] CmdRead  = DATA_BITS'(8'h02);
    localparam logic [DATA_BITS-1:0] RespAck  = DATA_BITS'(8'h01);
    localparam logic [DATA_BITS-1:0] RespNak  = DATA_BITS'(8'hEE);
`ifdef UART_RESP_CHKSUM_EN
    localparam logic [DATA_BITS-1:0] RespChkErr = DATA_BITS'(8'hEC);
`endif

    localparam int unsigned   CntW  = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CntW-1:0] ToMax = CntW'(TIMEOUT_CLKS - 1);

    typedef enum logic [3:0] {
        StIdle,
        StCmd,
        StAddr,
        StData,
`ifdef UART_RESP_CHKSUM_EN
        StChk,
`endif
        StExec,
        StRdWait,
        StTxHdr,
        StTxPay
`ifdef UART_RESP_CHKSUM_EN
        , StTxChk
`endif
    } state_e;

    state_e                 state_q;
    logic [DATA_BITS-1:0]   cmd_q;
    logic [DATA_BITS-1:0]   payload_q;
    logic [CntW-1:0]        to_cnt_q;
    logic                   in_rx;
    logic                   timed_out;
`ifdef UART_RESP_CHKSUM_EN
    logic [DATA_BITS-1:0]   chk_q;
`endif

    // Frame-receiving states are the only ones where the inter-byte timeout runs.
    always_comb begin
        in_rx = (state_q == StCmd) || (state_q == StAddr) || (state_q == StData);
`ifdef UART_RESP_CHKSUM_EN
        if (state_q == StChk) in_rx = 1'b1;
`endif
        timed_out = in_rx && !rx_valid && (to_cnt_q == ToMax);
    end

    // Frame parser, register strobes, response handshake and timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cmd_q      <= '0;
            payload_q  <= '0;
            to_cnt_q   <= '0;
            tx_vld     <= 1'b0;
            tx_data    <= '0;
            reg_wr_en  <= 1'b0;
            reg_rd_en  <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            busy       <= 1'b0;
            rx_overrun <= 1'b0;
`ifdef UART_RESP_CHKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;

            // Saturating counter; restarts on every received byte.
            if (rx_valid || !in_rx) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q != ToMax) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end

            // Bytes arriving while executing or responding are lost.
            if (rx_valid && !in_rx && (state_q != StIdle)) begin
                rx_overrun <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (rx_valid && (rx_data == SYNC_BYTE)) begin
                        state_q <= StCmd;
                        busy    <= 1'b1;
                    end
                end
                StCmd: begin
                    if (rx_valid) begin
                        cmd_q <= rx_data;
`ifdef UART_RESP_CHKSUM_EN
                        chk_q <= rx_data;
`endif
                        if ((rx_data == CmdWrite) || (rx_data == CmdRead)) begin
                            state_q <= StAddr;
                        end else begin
                            payload_q <= RespNak;
                            tx_vld    <= 1'b1;
                            tx_data   <= RESP_SYNC;
                            state_q   <= StTxHdr;
                        end
                    end else if (timed_out) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
                StAddr: begin
                    if (rx_valid) begin
                        reg_addr <= rx_data;
`ifdef UART_RESP_CHKSUM_EN
                        chk_q <= chk_q ^ rx_data;
                        state_q <= (cmd_q == CmdWrite) ? StData : StChk;
`else
                        if (cmd_q == CmdWrite) begin
                            state_q <= StData;
                        end else begin
                            state_q   <= StExec;
                            reg_rd_en <= 1'b1;
                        end
`endif
                    end else if (timed_out) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
                StData: begin
                    if (rx_valid) begin
                        reg_wdata <= rx_data;
`ifdef UART_RESP_CHKSUM_EN
                        chk_q   <= chk_q ^ rx_data;
                        state_q <= StChk;
`else
                        state_q   <= StExec;
                        reg_wr_en <= 1'b1;
`endif
                    end else if (timed_out) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
`ifdef UART_RESP_CHKSUM_EN
                StChk: begin
                    if (rx_valid) begin
                        if (rx_data == chk_q) begin
                            state_q   <= StExec;
                            reg_wr_en <= (cmd_q == CmdWrite);
                            reg_rd_en <= (cmd_q != CmdWrite);
                        end else begin
                            payload_q <= RespChkErr;
                            tx_vld    <= 1'b1;
                            tx_data   <= RESP_SYNC;
                            state_q   <= StTxHdr;
                        end
                    end else if (timed_out) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
`endif
                StExec: begin
                    if (cmd_q == CmdWrite) begin
                        payload_q <= RespAck;
                        tx_vld    <= 1'b1;
                        tx_data   <= RESP_SYNC;
                        state_q   <= StTxHdr;
                    end else begin
                        state_q <= StRdWait;
                    end
                end
                StRdWait: begin
                    payload_q <= reg_rdata;
                    tx_vld    <= 1'b1;
                    tx_data   <= RESP_SYNC;
                    state_q   <= StTxHdr;
                end
                StTxHdr: begin
                    // Drop tx_vld after each transfer so the gap cycle lets tx_rdy fall.
                    if (tx_vld && tx_rdy) begin
                        tx_vld  <= 1'b0;
                        tx_data <= payload_q;
                        state_q <= StTxPay;
                    end
                end
                StTxPay: begin
                    if (!tx_vld) begin
                        tx_vld <= 1'b1;
                    end else if (tx_rdy) begin
                        tx_vld <= 1'b0;
`ifdef UART_RESP_CHKSUM_EN
                        tx_data <= payload_q ^ RESP_SYNC;
                        state_q <= StTxChk;
`else
                        state_q <= StIdle;
                        busy    <= 1'b0;
`endif
                    end
                end
`ifdef UART_RESP_CHKSUM_EN
                StTxChk: begin
                    if (!tx_vld) begin
                        tx_vld <= 1'b1;
                    end else if (tx_rdy) begin
                        tx_vld  <= 1'b0;
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    tx_vld  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed self-checking bench for uart_reg_responder (short timeout for simulation).
// Honours UART_RESP_CHKSUM_EN when defined for the build.
module tb_uart_reg_responder;

    localparam int unsigned TO_CLKS = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_rdy;
    logic       tx_vld;
    logic [7:0] tx_data;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;
    logic       rx_overrun;

    int checks = 0;
    int failures = 0;

    logic [7:0] rd_value = 8'h00;
    logic [7:0] tx_q[$];
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         both_cnt = 0;
    int         gap_err = 0;
    logic       prev_xfer = 1'b0;

    uart_reg_responder #(
        .DATA_BITS    (8),
        .SYNC_BYTE    (8'hA5),
        .RESP_SYNC    (8'h5A),
        .TIMEOUT_CLKS (TO_CLKS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_rdy     (tx_rdy),
        .tx_vld     (tx_vld),
        .tx_data    (tx_data),
        .reg_wr_en  (reg_wr_en),
        .reg_rd_en  (reg_rd_en),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .busy       (busy),
        .rx_overrun (rx_overrun)
    );

    always #5 clk = ~clk;

    // Register slave: read data is valid only in the cycle after reg_rd_en.
    always @(posedge clk) reg_rdata <= reg_rd_en ? rd_value : 8'h00;

    // Passive monitor: strobe counts, transmitted bytes, handshake gap rule.
    always @(negedge clk) begin
        if (!reset) begin
            if (reg_wr_en) wr_cnt++;
            if (reg_rd_en) rd_cnt++;
            if (reg_wr_en && reg_rd_en) both_cnt++;
            if (tx_vld && prev_xfer) gap_err++;
            prev_xfer = tx_vld && tx_rdy;
            if (tx_vld && tx_rdy) tx_q.push_back(tx_data);
        end else begin
            prev_xfer = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (busy && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    // Compare and drain the captured response; third byte only with checksums.
    task automatic expect_tx(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2);
        logic [7:0] e[3];
        int         n;
        logic [7:0] g;
        e[0] = b0;
        e[1] = b1;
        e[2] = b2;
`ifdef UART_RESP_CHKSUM_EN
        n = 3;
`else
        n = 2;
`endif
        check({tag, "_len"}, tx_q.size(), n);
        for (int i = 0; i < n; i++) begin
            g = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
            check($sformatf("%s_b%0d", tag, i), {24'd0, g}, {24'd0, e[i]});
        end
        tx_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        int rd0;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_rdy   = 1'b1;
        idle_cycles(3);
        reset = 1'b0;

        check("rst_tx_vld", {31'd0, tx_vld}, 0);
        check("rst_tx_data", {24'd0, tx_data}, 0);
        check("rst_wr_en", {31'd0, reg_wr_en}, 0);
        check("rst_rd_en", {31'd0, reg_rd_en}, 0);
        check("rst_addr", {24'd0, reg_addr}, 0);
        check("rst_wdata", {24'd0, reg_wdata}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_overrun", {31'd0, rx_overrun}, 0);

        // WRITE A5 01 10 3C: strobe 1 cycle after last byte, tx_vld 2 cycles after.
        send_byte(8'hA5);
        check("wr_busy", {31'd0, busy}, 1);
        send_byte(8'h01);
        send_byte(8'h10);
`ifdef UART_RESP_CHKSUM_EN
        send_byte(8'h3C);
        send_byte(8'h2D);
`else
        send_byte(8'h3C);
`endif
        check("wr_strobe", {31'd0, reg_wr_en}, 1);
        check("wr_addr", {24'd0, reg_addr}, 32'h10);
        check("wr_wdata", {24'd0, reg_wdata}, 32'h3C);
        check("wr_vld_early", {31'd0, tx_vld}, 0);
        idle_cycles(1);
        check("wr_strobe_off", {31'd0, reg_wr_en}, 0);
        check("wr_vld", {31'd0, tx_vld}, 1);
        check("wr_hdr", {24'd0, tx_data}, 32'h5A);
        wait_idle("wr", 50);
        expect_tx("wr", 8'h5A, 8'h01, 8'h5B);
        check("wr_cnt", wr_cnt, 1);

        // READ A5 02 22 with reg_rdata C7: tx_vld 3 cycles after last byte.
        rd_value = 8'hC7;
        send_byte(8'hA5);
        send_byte(8'h02);
`ifdef UART_RESP_CHKSUM_EN
        send_byte(8'h22);
        send_byte(8'h20);
`else
        send_byte(8'h22);
`endif
        check("rd_strobe", {31'd0, reg_rd_en}, 1);
        check("rd_addr", {24'd0, reg_addr}, 32'h22);
        idle_cycles(1);
        check("rd_vld_early", {31'd0, tx_vld}, 0);
        idle_cycles(1);
        check("rd_vld", {31'd0, tx_vld}, 1);
        wait_idle("rd", 50);
        expect_tx("rd", 8'h5A, 8'hC7, 8'h9D);
        check("rd_cnt", rd_cnt, 1);
        check("rd_no_wr", wr_cnt, 1);

        // Leading garbage then bad command -> NAK, no register access.
        send_byte(8'h00);
        send_byte(8'hFF);
        check("nak_pre_busy", {31'd0, busy}, 0);
        send_byte(8'hA5);
        send_byte(8'h07);
        check("nak_vld", {31'd0, tx_vld}, 1);
        wait_idle("nak", 50);
        expect_tx("nak", 8'h5A, 8'hEE, 8'hB4);
        check("nak_wr", wr_cnt, 1);
        check("nak_rd", rd_cnt, 1);

        // Timeout: stall mid-frame, late byte must be ignored.
        send_byte(8'hA5);
        send_byte(8'h01);
        idle_cycles(TO_CLKS - 8);
        check("to_busy_before", {31'd0, busy}, 1);
        idle_cycles(8);
        check("to_busy_after", {31'd0, busy}, 0);
        send_byte(8'h10);
        idle_cycles(20);
        check("to_late_busy", {31'd0, busy}, 0);
        check("to_no_tx", tx_q.size(), 0);
        check("to_no_wr", wr_cnt, 1);
        check("to_overrun", {31'd0, rx_overrun}, 0);

`ifdef UART_RESP_CHKSUM_EN
        // Bad checksum: no write, error response.
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'h3C);
        send_byte(8'h00);
        check("chk_no_strobe", {31'd0, reg_wr_en}, 0);
        wait_idle("chk", 50);
        expect_tx("chk", 8'h5A, 8'hEC, 8'hB6);
        check("chk_no_wr", wr_cnt, 1);
`endif

        // Stalled transmitter during READ response plus an overrun byte.
        rd_value = 8'h81;
        tx_rdy   = 1'b0;
        rd0      = rd_cnt;
        wr0      = wr_cnt;
        send_byte(8'hA5);
        send_byte(8'h02);
`ifdef UART_RESP_CHKSUM_EN
        send_byte(8'h22);
        send_byte(8'h20);
`else
        send_byte(8'h22);
`endif
        idle_cycles(250);
        check("st_vld_mid", {31'd0, tx_vld}, 1);
        check("st_data_mid", {24'd0, tx_data}, 32'h5A);
        send_byte(8'h55);
        idle_cycles(250);
        check("st_vld_end", {31'd0, tx_vld}, 1);
        check("st_data_end", {24'd0, tx_data}, 32'h5A);
        check("st_overrun", {31'd0, rx_overrun}, 1);
        check("st_no_tx", tx_q.size(), 0);
        tx_rdy = 1'b1;
        wait_idle("st", 50);
        expect_tx("st", 8'h5A, 8'h81, 8'hDB);
        check("st_rd_cnt", rd_cnt, rd0 + 1);
        check("st_wr_cnt", wr_cnt, wr0);
        check("st_overrun_sticky", {31'd0, rx_overrun}, 1);

        check("strobe_excl", both_cnt, 0);
        check("tx_gap", gap_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
